// File: rtl/dc_bu_line_ring_manager.sv
// Line-buffer ring manager: rotates the write buffer and TAP_NUM read taps on each
// completed line, replicating the oldest valid line onto missing taps at frame top.
module dc_bu_line_ring_manager #(
  parameter int BUFFER_NUM   = 5,
  parameter int TAP_NUM      = 4,
  parameter bit REPLICATE_EN = 1'b1,
  parameter int IDX_W        = $clog2(BUFFER_NUM),
  parameter int CNT_W        = $clog2(TAP_NUM + 1)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          sof,
  input  logic                          next_line,
  input  logic                          no_func_switch,
  output logic [BUFFER_NUM-1:0]         write_buff,
  output logic [IDX_W-1:0]              write_idx,
  output logic [TAP_NUM*BUFFER_NUM-1:0] tap_buff,
  output logic [TAP_NUM*IDX_W-1:0]      tap_idx,
  output logic [CNT_W-1:0]              lines_valid,
  output logic                          taps_ready
);

  if (BUFFER_NUM < TAP_NUM + 1 || TAP_NUM < 1) begin : g_bad_params
    $error("dc_bu_line_ring_manager: need TAP_NUM >= 1 and BUFFER_NUM >= TAP_NUM+1");
  end

  localparam logic [BUFFER_NUM-1:0] ONE_HOT_0 = {{(BUFFER_NUM-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] wp_reg, wp_next;
  logic [CNT_W-1:0] fc_reg, fc_next;
  logic             adv, clr;

  assign adv = en & next_line & ~no_func_switch;
  assign clr = en & sof;

  // Ring wrap is an explicit compare, since BUFFER_NUM need not be a power of two.
  always_comb begin
    wp_next = wp_reg;
    fc_next = fc_reg;
    if (adv) begin
      wp_next = (wp_reg == IDX_W'(BUFFER_NUM - 1)) ? '0 : wp_reg + IDX_W'(1);
    end
    if (clr) begin
      fc_next = '0;
    end else if (adv && fc_reg != CNT_W'(TAP_NUM)) begin
      fc_next = fc_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wp_reg <= '0;
      fc_reg <= '0;
    end else begin
      wp_reg <= wp_next;
      fc_reg <= fc_next;
    end
  end

  assign write_idx   = wp_reg;
  assign write_buff  = ONE_HOT_0 << wp_reg;
  assign lines_valid = fc_reg;
  assign taps_ready  = (fc_reg == CNT_W'(TAP_NUM));

  for (genvar gi = 0; gi < TAP_NUM; gi++) begin : g_tap
    int k_eff;
    int slot;

    // Taps older than the fill count collapse onto the oldest valid line.
    always_comb begin
      k_eff = gi;
      if (REPLICATE_EN) begin
        if (k_eff < TAP_NUM - int'(fc_reg)) k_eff = TAP_NUM - int'(fc_reg);
        if (k_eff > TAP_NUM - 1) k_eff = TAP_NUM - 1;
      end
      slot = int'(wp_reg) + BUFFER_NUM - TAP_NUM + k_eff;
      if (slot >= BUFFER_NUM) slot = slot - BUFFER_NUM;
    end

    assign tap_idx[gi*IDX_W +: IDX_W]            = IDX_W'(slot);
    assign tap_buff[gi*BUFFER_NUM +: BUFFER_NUM] = ONE_HOT_0 << tap_idx[gi*IDX_W +: IDX_W];
  end

endmodule

// File: tb/tb_dc_bu_line_ring_manager.sv
// Scoreboard bench for dc_bu_line_ring_manager: three configurations, directed vectors,
// expected mappings pushed on stimulus and compared by an independent monitor.
module tb_dc_bu_line_ring_manager;

  logic clk = 1'b0;
  logic nrst;
  logic en_a, en_b, en_c, sof, next_line, nfs;

  always #5 clk = ~clk;

  // A: 5 buffers / 4 taps / replicate; B: 5/4 fixed ring; C: 7/4 fixed ring
  logic [4:0]  wb_a, wb_b;
  logic [6:0]  wb_c;
  logic [2:0]  wi_a, wi_b, wi_c;
  logic [19:0] tb_a, tb_b;
  logic [27:0] tb_c;
  logic [11:0] ti_a, ti_b, ti_c;
  logic [2:0]  lv_a, lv_b, lv_c;
  logic        rd_a, rd_b, rd_c;

  dc_bu_line_ring_manager #(.BUFFER_NUM(5), .TAP_NUM(4), .REPLICATE_EN(1'b1)) dut_a (
    .clk(clk), .nrst(nrst), .en(en_a), .sof(sof), .next_line(next_line), .no_func_switch(nfs),
    .write_buff(wb_a), .write_idx(wi_a), .tap_buff(tb_a), .tap_idx(ti_a),
    .lines_valid(lv_a), .taps_ready(rd_a));

  dc_bu_line_ring_manager #(.BUFFER_NUM(5), .TAP_NUM(4), .REPLICATE_EN(1'b0)) dut_b (
    .clk(clk), .nrst(nrst), .en(en_b), .sof(sof), .next_line(next_line), .no_func_switch(nfs),
    .write_buff(wb_b), .write_idx(wi_b), .tap_buff(tb_b), .tap_idx(ti_b),
    .lines_valid(lv_b), .taps_ready(rd_b));

  dc_bu_line_ring_manager #(.BUFFER_NUM(7), .TAP_NUM(4), .REPLICATE_EN(1'b0)) dut_c (
    .clk(clk), .nrst(nrst), .en(en_c), .sof(sof), .next_line(next_line), .no_func_switch(nfs),
    .write_buff(wb_c), .write_idx(wi_c), .tap_buff(tb_c), .tap_idx(ti_c),
    .lines_valid(lv_c), .taps_ready(rd_c));

  typedef struct {
    int    sel;
    string nm;
    int    wi;
    int    t0, t1, t2, t3;
    int    lv;
    bit    rd;
  } exp_t;

  exp_t sbq[$];
  event sample_now;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string field, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, field, act, expv);
    end
  endtask

  task automatic check_entry(input exp_t x);
    logic [7:0]  wb;
    logic [2:0]  wi;
    logic [63:0] tb;
    logic [11:0] ti;
    logic [2:0]  lv;
    logic        rd;
    int          bn;
    int          et[4];
    case (x.sel)
      0:       begin wb = 8'(wb_a); wi = wi_a; tb = 64'(tb_a); ti = ti_a; lv = lv_a; rd = rd_a; bn = 5; end
      1:       begin wb = 8'(wb_b); wi = wi_b; tb = 64'(tb_b); ti = ti_b; lv = lv_b; rd = rd_b; bn = 5; end
      default: begin wb = 8'(wb_c); wi = wi_c; tb = 64'(tb_c); ti = ti_c; lv = lv_c; rd = rd_c; bn = 7; end
    endcase
    et[0] = x.t0; et[1] = x.t1; et[2] = x.t2; et[3] = x.t3;
    $display("txn %s: dut=%0d write_idx=%0d taps=%0d,%0d,%0d,%0d lines_valid=%0d taps_ready=%0d",
             x.nm, x.sel, wi, ti[2:0], ti[5:3], ti[8:6], ti[11:9], lv, rd);
    chk(x.nm, "write_idx", int'(wi), x.wi);
    chk(x.nm, "write_buff", int'(wb), 1 << x.wi);
    for (int k = 0; k < 4; k++) begin
      chk(x.nm, $sformatf("tap_idx[%0d]", k), int'(ti[k*3 +: 3]), et[k]);
      chk(x.nm, $sformatf("tap_buff[%0d]", k),
          int'((tb >> (k * bn)) & ((64'd1 << bn) - 64'd1)), 1 << et[k]);
    end
    chk(x.nm, "lines_valid", int'(lv), x.lv);
    chk(x.nm, "taps_ready", int'(rd), int'(x.rd));
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk or sample_now);
      while (sbq.size() > 0) begin
        x = sbq.pop_front();
        check_entry(x);
      end
    end
  end

  task automatic push_exp(input int sel, input string nm, input int wi,
                          input int t0, input int t1, input int t2, input int t3,
                          input int lv, input bit rd);
    exp_t x;
    x.sel = sel; x.nm = nm; x.wi = wi;
    x.t0 = t0; x.t1 = t1; x.t2 = t2; x.t3 = t3;
    x.lv = lv; x.rd = rd;
    sbq.push_back(x);
  endtask

  // One clock of stimulus to the selected instance, then the hand-computed result.
  task automatic step(input int sel, input bit e, input bit s, input bit n, input bit f,
                      input string nm, input int wi,
                      input int t0, input int t1, input int t2, input int t3,
                      input int lv, input bit rd);
    en_a = (sel == 0) && e;
    en_b = (sel == 1) && e;
    en_c = (sel == 2) && e;
    sof = s; next_line = n; nfs = f;
    @(posedge clk);
    #1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    sof = 1'b0; next_line = 1'b0; nfs = 1'b0;
    push_exp(sel, nm, wi, t0, t1, t2, t3, lv, rd);
  endtask

  initial begin : stimulus
    nrst = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    sof = 1'b0; next_line = 1'b0; nfs = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Fixed ring, 5 buffers
    step(1, 0, 0, 0, 0, "b_reset", 0, 1, 2, 3, 4, 0, 0);
    step(1, 1, 0, 1, 0, "b_adv1",  1, 2, 3, 4, 0, 1, 0);
    step(1, 1, 0, 1, 0, "b_adv2",  2, 3, 4, 0, 1, 2, 0);
    step(1, 1, 0, 1, 0, "b_adv3",  3, 4, 0, 1, 2, 3, 0);
    step(1, 1, 0, 1, 0, "b_adv4",  4, 0, 1, 2, 3, 4, 1);
    step(1, 1, 0, 1, 0, "b_adv5",  0, 1, 2, 3, 4, 4, 1);

    // Replicating ring, 5 buffers
    step(0, 0, 0, 0, 0, "a_reset", 0, 4, 4, 4, 4, 0, 0);
    step(0, 1, 1, 0, 0, "a_sof",   0, 4, 4, 4, 4, 0, 0);
    step(0, 1, 0, 1, 0, "a_adv1",  1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0, "a_adv2",  2, 0, 0, 0, 1, 2, 0);
    step(0, 1, 0, 1, 0, "a_adv3",  3, 0, 0, 1, 2, 3, 0);
    step(0, 1, 0, 1, 0, "a_adv4",  4, 0, 1, 2, 3, 4, 1);
    step(0, 1, 0, 1, 0, "a_adv5",  0, 1, 2, 3, 4, 4, 1);
    step(0, 1, 0, 1, 0, "a_adv6",  1, 2, 3, 4, 0, 4, 1);
    step(0, 1, 0, 1, 0, "a_adv7",  2, 3, 4, 0, 1, 4, 1);
    step(0, 1, 1, 1, 0, "a_sof_adv", 3, 2, 2, 2, 2, 0, 0);
    step(0, 1, 0, 1, 1, "a_nfs",     3, 2, 2, 2, 2, 0, 0);
    step(0, 0, 1, 1, 0, "a_en_low",  3, 2, 2, 2, 2, 0, 0);
    step(0, 1, 0, 1, 0, "a_adv8",    4, 3, 3, 3, 3, 1, 0);
    step(0, 1, 0, 1, 0, "a_adv9",    0, 3, 3, 3, 4, 2, 0);
    step(0, 1, 0, 1, 0, "a_adv10",   1, 3, 3, 4, 0, 3, 0);
    step(0, 1, 1, 0, 0, "a_sof2",    1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, "a_adv11",   2, 1, 1, 1, 1, 1, 0);
    step(0, 1, 0, 1, 0, "a_adv12",   3, 1, 1, 1, 2, 2, 0);

    // Asynchronous reset mid-frame, checked before the next clock edge
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    push_exp(0, "a_async_rst", 0, 4, 4, 4, 4, 0, 0);
    -> sample_now;
    @(posedge clk);
    #1 nrst = 1'b1;
    step(0, 1, 0, 1, 0, "a_post_rst", 1, 0, 0, 0, 0, 1, 0);

    // Fixed ring, 7 buffers: wrap at 6 -> 0
    step(2, 0, 0, 0, 0, "c_reset", 0, 3, 4, 5, 6, 0, 0);
    step(2, 1, 0, 1, 0, "c_adv1",  1, 4, 5, 6, 0, 1, 0);
    step(2, 1, 0, 1, 0, "c_adv2",  2, 5, 6, 0, 1, 2, 0);
    step(2, 1, 0, 1, 0, "c_adv3",  3, 6, 0, 1, 2, 3, 0);
    step(2, 1, 0, 1, 0, "c_adv4",  4, 0, 1, 2, 3, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv5",  5, 1, 2, 3, 4, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv6",  6, 2, 3, 4, 5, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv7",  0, 3, 4, 5, 6, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv8",  1, 4, 5, 6, 0, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv9",  2, 5, 6, 0, 1, 4, 1);
    step(2, 1, 0, 1, 0, "c_adv10", 3, 6, 0, 1, 2, 4, 1);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_bu_line_ring_manager.md
Name: dc_bu_line_ring_manager

Overview:
Parametrised line-buffer ring manager for the buffering unit. It assigns one of BUFFER_NUM line buffers as the write target and TAP_NUM buffers as vertical read taps (oldest to newest), rotating the assignment on each completed line. It tracks how many valid lines the current frame holds and, at the top of a frame, remaps missing taps onto the oldest valid line so the vertical filter sees edge replication. Sits between line-timing control and the line-buffer RAM mux / vertical scaler taps.

Parameters:
BUFFER_NUM, 5, number of physical line buffers; must be >= TAP_NUM+1 (elaboration error otherwise)
TAP_NUM, 4, number of vertical read taps; must be >= 1
REPLICATE_EN, 1, 1 = top-edge replication from fill count; 0 = fixed ring mapping, fill count ignored for tap mapping
IDX_W, $clog2(BUFFER_NUM), binary buffer index width (derived, not overridden)
CNT_W, $clog2(TAP_NUM+1), fill-count width (derived)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
en  in  1  global enable; all state updates, including sof, require en=1
sof  in  1  start-of-frame pulse; clears fill count
next_line  in  1  pulse: write line complete
no_func_switch  in  1  suppresses rotation on next_line
write_buff  out  BUFFER_NUM  one-hot write buffer select
write_idx  out  IDX_W  binary write buffer index
tap_buff  out  TAP_NUM*BUFFER_NUM  one-hot select per tap; slice k = [k*BUFFER_NUM +: BUFFER_NUM]; tap 0 oldest, tap TAP_NUM-1 newest
tap_idx  out  TAP_NUM*IDX_W  binary index per tap, same slicing by IDX_W
lines_valid  out  CNT_W  lines written in current frame, saturating at TAP_NUM
taps_ready  out  1  1 when lines_valid == TAP_NUM

Behaviour:
- State: wp (IDX_W, write index), fc (CNT_W, fill count). All outputs decode from these registers only; there is no combinational path from any input to any output.
- Reset (nrst=0, async): wp=0, fc=0.
- adv = en & next_line & ~no_func_switch; clr = en & sof.
- adv: wp <= (wp==BUFFER_NUM-1) ? 0 : wp+1. Wrap is modulo BUFFER_NUM and is not a power-of-two mask.
- fc update:
  - clr=1 -> fc <= 0, regardless of adv. wp still advances if adv; the line just completed belongs to the previous frame and is discarded.
  - Else adv=1 -> fc <= min(fc+1, TAP_NUM).
  - Else fc holds.
- en=0: all state holds, regardless of sof, next_line or no_func_switch.
- Latency: outputs reflect the update on the cycle after the adv/clr edge.
- Tap mapping, ring slot for tap k:
  - Base: base(k) = (wp - TAP_NUM + k) mod BUFFER_NUM. Tap TAP_NUM-1 = last written buffer; write buffer is never a tap.
  - REPLICATE_EN=1: k_eff = min(max(k, TAP_NUM - fc), TAP_NUM-1); tap_idx[k] = base(k_eff).
  - fc=0: all taps point to wp-1 mod N; taps_ready=0.
  - REPLICATE_EN=0: tap_idx[k] = base(k) always. lines_valid and taps_ready are still produced.
- write_buff = 1<<wp; tap_buff[k] = 1<<tap_idx[k]. Exactly one bit set in every one-hot field at all times.
- write_idx = wp; lines_valid = fc; taps_ready = (fc==TAP_NUM).
- Mid-operation reset returns immediately (asynchronously) to reset values. The first adv after release behaves as from reset.
- next_line with no_func_switch=1: no rotation and no fc increment.

Test Plan:
- Reset, defaults, REPLICATE_EN=0 -> write_idx=0, tap_idx={1,2,3,4} (tap0..3), write_buff=5'b00001, lines_valid=0, taps_ready=0.
- Defaults, REPLICATE_EN=0, 5 adv pulses -> write_idx 1,2,3,4,0. After pulse 1: taps={2,3,4,0}. After pulse 5: mapping equals reset mapping. Every one-hot field has popcount=1.
- Defaults, REPLICATE_EN=1: sof, then adv x1 -> fc=1, write_idx=1, taps all=0. Adv x2 -> fc=2, write_idx=2, taps={0,0,0,1}. Adv x4 total -> fc=4, taps_ready=1, taps={0,1,2,3}. Further adv -> fc stays 4.
- sof and adv in the same cycle with fc=4, wp=2 -> wp=3, fc=0, taps all=2. next_line with no_func_switch=1 -> wp and fc unchanged. en=0 with sof/adv -> no change.
- BUFFER_NUM=7, TAP_NUM=4, REPLICATE_EN=0, 10 adv from reset -> wp=3, taps={6,0,1,2}. Wrap occurs at 6->0, never at 7.
- nrst asserted mid-frame (wp=3, fc=2) -> wp=0, fc=0 asynchronously, without waiting for a clk edge. Next adv -> wp=1, fc=1.
